// File: rtl/seg7_scan_driver.sv
`default_nettype none
// =============================================================================
// Module      : seg7_scan_driver
// Description : Rebuilds a 4-digit BCD bank from a time-multiplexed digit
//               stream and scans it onto a common-anode 4-digit 7-seg display,
//               with react dashes and saturation blink.
//               Optional macro SEG7_LZB_EN enables leading-zero blanking.
// Revision    : 1.0
// =============================================================================
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV    = 50,
    parameter int unsigned BLINK_DIV      = 12500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic [1:0] digit_sel,
    input  logic       react,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int unsigned RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RCNT_W-1:0] REFRESH_LAST = RCNT_W'(REFRESH_DIV - 1);
    localparam logic [BCNT_W-1:0] BLINK_LAST   = BCNT_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0] AN_POL  = {4{AN_ACTIVE_LOW}};
    localparam logic [6:0] SEG_G   = 7'b100_0000;

    logic [3:0]        bank [4];
    logic [RCNT_W-1:0] refresh_cnt;
    logic [1:0]        scan_idx;
    logic [BCNT_W-1:0] blink_cnt;
    logic              blink_phase;

    logic              refresh_wrap;
    logic              blink_run;
    logic              lzb_blank;
    logic [6:0]        lit_seg;
    logic              lit_dp;
    logic [3:0]        lit_an;
    logic              shown;

    assign refresh_wrap = (refresh_cnt == REFRESH_LAST);
    assign blink_run    = (bank[3] == 4'd9) && !react;

    // digit_in lags its select by one cycle, so it belongs to slot sel-1
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                bank[k] <= 4'd0;
            end
        end else begin
            bank[digit_sel - 2'd1] <= digit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !blink_run) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

`ifdef SEG7_LZB_EN
    logic [3:0] zero_lead;

    always_comb begin
        zero_lead    = 4'b0000;
        zero_lead[3] = (bank[3] == 4'd0);
        zero_lead[2] = zero_lead[3] && (bank[2] == 4'd0);
        zero_lead[1] = zero_lead[2] && (bank[1] == 4'd0);
    end

    assign lzb_blank = !react && zero_lead[scan_idx];
`else
    assign lzb_blank = 1'b0;
`endif

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h00;
        endcase
    endfunction

    // Logical (active-high) view; polarity is applied only at the output flops
    always_comb begin
        lit_seg = react ? SEG_G : bcd_to_seg(bank[scan_idx]);
        shown   = react || !blink_phase;
        if (lzb_blank) begin
            lit_seg = 7'h00;
            shown   = 1'b0;
        end
        lit_dp = !react && (scan_idx == 2'd3) && shown;
        lit_an = shown ? (4'b0001 << scan_idx) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_POL;
            dp  <= SEG_ACTIVE_LOW;
            an  <= AN_POL;
        end else begin
            seg <= lit_seg ^ SEG_POL;
            dp  <= lit_dp ^ SEG_ACTIVE_LOW;
            an  <= lit_an ^ AN_POL;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// =============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver with a cycle model
//               and directed literal checks; honours SEG7_LZB_EN.
// Revision    : 1.0
// =============================================================================
module tb_seg7_scan_driver;

    localparam int REF = 4;
    localparam int BL  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic [1:0] digit_sel;
    logic       react;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    seg7_scan_driver #(
        .REFRESH_DIV    (REF),
        .BLINK_DIV      (BL),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digit_in  (digit_in),
        .digit_sel (digit_sel),
        .react     (react),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    always #5 clk = ~clk;

    string seg_names [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                              "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] pattern(input int v);
        logic [6:0] r;
        string      s;
        r = 7'h00;
        if (v <= 9) begin
            s = seg_names[v];
            for (int i = 0; i < s.len(); i++) begin
                r[int'(s[i]) - 97] = 1'b1;
            end
        end
        return r;
    endfunction

    // Returns {seg, dp, an} as the pins must read (active-low everything)
    function automatic logic [11:0] model_out(input logic [15:0] bk, input int scan,
                                              input bit rc, input bit phase);
        logic [6:0] lit;
        bit         on;
        bit         dpl;
        bit         blank;
        lit   = rc ? pattern(-1) | 7'b100_0000 : pattern(int'(bk[4*scan +: 4]));
        on    = rc || !phase;
        blank = 1'b0;
`ifdef SEG7_LZB_EN
        if (!rc && scan > 0) begin
            blank = 1'b1;
            for (int k = scan; k < 4; k++) begin
                if (bk[4*k +: 4] != 4'd0) blank = 1'b0;
            end
        end
`endif
        if (blank) begin
            lit = 7'h00;
            on  = 1'b0;
        end
        dpl = !rc && scan == 3 && on;
        return {~lit, ~dpl, on ? ~(4'b0001 << scan) : 4'hF};
    endfunction

    logic [15:0] mb;
    int          t;
    int          run;
    logic [11:0] exp_out;

    always @(posedge clk) begin
        if (rst) begin
            mb      <= 16'h0000;
            t       <= 0;
            run     <= 0;
            exp_out <= {7'h7F, 1'b1, 4'hF};
        end else begin
            exp_out <= model_out(mb, (t / REF) % 4, react, ((run / BL) % 2) == 1);
            run     <= (mb[15:12] == 4'd9 && !react) ? run + 1 : 0;
            mb[4*((int'(digit_sel) + 3) % 4) +: 4] <= digit_in;
            t       <= t + 1;
        end
    end

    int         checks   = 0;
    int         failures = 0;
    bit         chk_en   = 1'b0;
    logic [1:0] sel_q    = 2'd0;
    logic [3:0] vals [4];

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
        end
    endtask

    task automatic flag(input string nm, input bit bad, input logic [6:0] act);
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h", nm, $time, act);
        end
    endtask

    // One cycle: compare against model, then advance the producer stream
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            chk("mdl_seg", seg, exp_out[11:5]);
            chk("mdl_dp", {6'd0, dp}, {6'd0, exp_out[4]});
            chk("mdl_an", {3'd0, an}, {3'd0, exp_out[3:0]});
        end
        sel_q     = sel_q + 2'd1;
        digit_sel = sel_q;
        digit_in  = vals[sel_q - 2'd1];
    endtask

    logic [6:0] dig_tbl [4];
    bit         off_hist [48];

    initial begin
        rst       = 1'b1;
        react     = 1'b0;
        digit_sel = 2'd0;
        digit_in  = 4'd0;
        for (int k = 0; k < 4; k++) vals[k] = 4'd0;
        dig_tbl[0] = 7'h19;
        dig_tbl[1] = 7'h30;
        dig_tbl[2] = 7'h24;
        dig_tbl[3] = 7'h79;

        // Reset state and first post-reset scan
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", {6'd0, dp}, 7'd1);
        chk("rst_an", {3'd0, an}, 7'h0F);
        rst = 1'b0;
        tick();
        chk("first_an", {3'd0, an}, 7'b000_1110);
        chk("first_seg", seg, 7'b100_0000);

        // Bank 1234 scanned with REFRESH_DIV=4
        vals[3] = 4'd1; vals[2] = 4'd2; vals[1] = 4'd3; vals[0] = 4'd4;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("scan_an", {3'd0, an}, {3'd0, ~(4'b0001 << (i / 4))});
            chk("scan_seg", seg, dig_tbl[i / 4]);
            chk("scan_dp", {6'd0, dp}, {6'd0, (i / 4) != 3});
        end

        // Reset while digit 2 is being shown
        begin
            bit found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                tick();
                if (an == 4'b1011) found = 1'b1;
            end
            flag("wait_scan2", !found, {3'd0, an});
        end
        rst = 1'b1;
        tick();
        chk("mid_rst_an", {3'd0, an}, 7'h0F);
        chk("mid_rst_seg", seg, 7'h7F);
        rst = 1'b0;
        tick();
        chk("restart_an", {3'd0, an}, 7'b000_1110);
        chk("restart_seg", seg, 7'b100_0000);
        repeat (8) tick();

        // React override
        react = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("react_seg", seg, 7'b011_1111);
            chk("react_dp", {6'd0, dp}, 7'd1);
        end
        react = 1'b0;
        tick();
        flag("react_release", seg == 7'b011_1111, seg);

        // Saturation blink: off/on runs of exactly BL cycles
        vals[3] = 4'd9;
        repeat (6) tick();
        for (int i = 0; i < 48; i++) begin
            tick();
            off_hist[i] = (an == 4'hF);
        end
        begin
            int start = -1;
            int trans = 0;
            for (int i = 1; i < 48; i++) begin
                if (off_hist[i] != off_hist[i-1]) begin
                    if (start >= 0) chk("blink_run", 7'(i - start), 7'(BL));
                    start = i;
                    trans++;
                end
            end
            flag("blink_trans", trans < 4, 7'(trans));
        end
        vals[3] = 4'd8;
        repeat (4) tick();
        begin
            bit dark = 1'b0;
            for (int i = 0; i < 32; i++) begin
                tick();
                if (an == 4'hF) dark = 1'b1;
            end
            flag("no_blink", dark, 7'd0);
        end

        // Leading zeros: 0045 then 0000
        vals[3] = 4'd0; vals[2] = 4'd0; vals[1] = 4'd4; vals[0] = 4'd5;
        repeat (8) tick();
        begin
            bit seen3 = 1'b0;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (an == 4'b0111) seen3 = 1'b1;
                if (an == 4'b1101) chk("lz_d1", seg, 7'h19);
                if (an == 4'b1110) chk("lz_d0", seg, 7'h12);
            end
`ifdef SEG7_LZB_EN
            flag("lz_upper_shown", seen3, 7'd0);
`else
            flag("lz_upper_missing", !seen3, 7'd0);
`endif
        end
        vals[1] = 4'd0; vals[0] = 4'd0;
        repeat (8) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
`ifdef SEG7_LZB_EN
            flag("lz_zero_an", an != 4'b1110 && an != 4'hF, {3'd0, an});
`endif
            if (an == 4'b1110) chk("lz_zero_seg", seg, 7'b100_0000);
        end
        react = 1'b1;
        repeat (8) tick();
        react = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
